riscv_seq_alu: RTL

// Parametrised RV32I-style integer ALU execute unit with valid/ready handshakes on

---
 rtl/riscv_seq_alu.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_seq_alu.sv
`timescale 1ns/1ps
// riscv_seq_alu
// RV32I-style integer ALU execute unit with valid/ready handshakes on both
// sides. A shift is done either by a single-cycle barrel shifter
// (SHIFT_SERIAL=0) or by an iterative shifter that moves SHIFT_STEP bits per
// cycle, falling back to single-bit steps for the remainder. Every result
// carries branch-compare flags latched from the operands at acceptance.
//
// Ports
//   CLK        in   1     clock, rising edge
//   RESET      in   1     asynchronous, active-high reset
//   in_valid   in   1     operation presented
//   in_ready   out  1     unit can accept an operation this cycle
//   funct3     in   3     RV funct3
//   alt        in   1     funct7[5]: SUB (register form) / SRA
//   is_reg     in   1     1 = register-register op, 0 = immediate op
//   in1        in   XLEN  operand 1 (rs1)
//   in2        in   XLEN  operand 2 (rs2 or Iimm); shamt = in2[log2(XLEN)-1:0]
//   out_valid  out  1     result/flags valid
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  ALU result
//   eq/lt/ltu  out  1     in1==in2, signed in1<in2, unsigned in1<in2

module riscv_seq_alu #(
    parameter int XLEN         = 32,
    parameter int SHIFT_SERIAL = 1,
    parameter int SHIFT_STEP   = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic            is_reg,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] STEP_AMT = SHW'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic                   accept;
    logic                   start_serial;
    logic [SHW-1:0]         shamt;
    logic signed [XLEN-1:0] in1_s;
    logic signed [XLEN-1:0] in2_s;
    logic                   flag_eq, flag_lt, flag_ltu;
    logic [XLEN-1:0]        alu_value;

    // Iterative shifter working state, captured at acceptance.
    logic [XLEN-1:0]        shift_reg;
    logic [SHW-1:0]         count;
    logic                   sh_left;
    logic                   sh_arith;
    logic                   big_step;
    logic [SHW-1:0]         count_dec;
    logic [XLEN-1:0]        shift_next;
    logic                   last_iter;

    // Single-cycle result for every op. In serial mode shift ops only reach
    // here with shamt==0, so their result is in1 and no barrel shifter is built.
    function automatic logic [XLEN-1:0] alu_op(
        input logic [2:0]      f3,
        input logic            a,
        input logic            r,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y,
        input logic            slt_bit,
        input logic            sltu_bit
    );
        logic signed [XLEN-1:0] xs;
        logic [XLEN-1:0]        sra_v;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        res;
        xs    = x;
        sh    = y[SHW-1:0];
        sra_v = xs >>> sh;
        case (f3)
            3'b000:  res = (a && r) ? x - y : x + y;
            3'b001:  res = (SHIFT_SERIAL != 0) ? x : x << sh;
            3'b010:  res = {{(XLEN-1){1'b0}}, slt_bit};
            3'b011:  res = {{(XLEN-1){1'b0}}, sltu_bit};
            3'b100:  res = x ^ y;
            3'b101:  res = (SHIFT_SERIAL != 0) ? x : (a ? sra_v : x >> sh);
            3'b110:  res = x | y;
            default: res = x & y;
        endcase
        return res;
    endfunction

    // One iteration of the serial shifter: SHIFT_STEP bits or a single bit.
    function automatic logic [XLEN-1:0] step_shift(
        input logic [XLEN-1:0] x,
        input logic            left,
        input logic            arith,
        input logic            big
    );
        logic signed [XLEN-1:0] xs;
        logic signed [XLEN-1:0] sra_v;
        logic [XLEN-1:0]        res;
        xs    = x;
        sra_v = big ? (xs >>> SHIFT_STEP) : (xs >>> 1);
        if (left)
            res = big ? (x << SHIFT_STEP) : (x << 1);
        else if (arith)
            res = sra_v;
        else
            res = big ? (x >> SHIFT_STEP) : (x >> 1);
        return res;
    endfunction

    // in_ready is held low while reset is asserted.
    assign in_ready  = !RESET && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign in1_s    = in1;
    assign in2_s    = in2;
    assign flag_eq  = (in1 == in2);
    assign flag_lt  = (in1_s < in2_s);
    assign flag_ltu = (in1 < in2);

    assign shamt        = in2[SHW-1:0];
    assign start_serial = (SHIFT_SERIAL != 0) && (funct3[1:0] == 2'b01) && (shamt != '0);
    assign alu_value    = alu_op(funct3, alt, is_reg, in1, in2, flag_lt, flag_ltu);

    assign big_step   = (count >= STEP_AMT);
    assign count_dec  = count - (big_step ? STEP_AMT : SHW'(1));
    assign shift_next = step_shift(shift_reg, sh_left, sh_arith, big_step);
    assign last_iter  = (count_dec == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = start_serial ? SHIFT : DONE;
                else if ((state == DONE) && out_ready)
                    state_next = IDLE;
            end
            SHIFT: begin
                if (last_iter)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control, result and flags: reset to a known idle state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            result <= '0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            ltu    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                eq  <= flag_eq;
                lt  <= flag_lt;
                ltu <= flag_ltu;
                if (!start_serial)
                    result <= alu_value;
            end else if ((state == SHIFT) && last_iter) begin
                result <= shift_next;
            end
        end
    end

    // Shifter datapath: only meaningful while in SHIFT, so no reset needed.
    always_ff @(posedge CLK) begin
        if (accept) begin
            shift_reg <= in1;
            count     <= shamt;
            sh_left   <= !funct3[2];
            sh_arith  <= alt;
        end else if (state == SHIFT) begin
            shift_reg <= shift_next;
            count     <= count_dec;
        end
    end

endmodule
